// File: rtl/regfile_sb_if.sv
// Register-file port bundle between ID/WB (master) and the register file
// with scoreboard (slave). Read addresses/data are packed per port.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
);
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                reg_wrt;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     din;
    logic                flush;
    logic [AW:0]         busy_cnt;
    logic                any_busy;

    modport master (
        output rs_addr, iss_valid, iss_rd, reg_wrt, rd, din, flush,
        input  rs_data, rs_busy, busy_cnt, any_busy
    );

    modport slave (
        input  rs_addr, iss_valid, iss_rd, reg_wrt, rd, din, flush,
        output rs_data, rs_busy, busy_cnt, any_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard for RAW hazard
// detection in ID. Register 0 is hard-wired to zero and never busy.
// Optional macro REGFILE_BYPASS_EN: forwards the same-cycle WB write to the
// read ports and masks the busy bit of a register being written back.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic         clk_regs,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     busy;
    logic [NREG-1:0]     busy_nxt;
    logic [AW:0]         busy_cnt;
    logic [AW:0]         cnt_nxt;
    logic [NRD*XLEN-1:0] rs_data_w;
    logic [NRD-1:0]      rs_busy_w;
    logic                wr_en;

    assign wr_en = bus.reg_wrt && (bus.rd != '0);

    // Data array: cleared on reset, otherwise only the WB destination is written.
    always_ff @(posedge clk_regs) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rd] <= bus.din;
        end
    end

    // Next busy vector: flush keeps only the same-cycle issue; issue beats writeback.
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (bus.flush) begin
                busy_nxt[r] = bus.iss_valid && (bus.iss_rd == AW'(r));
            end else if (bus.iss_valid && (bus.iss_rd == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (bus.reg_wrt && (bus.rd == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end else begin
                busy_nxt[r] = busy[r];
            end
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
        end
    end

    // Scoreboard bits and their population count move together.
    always_ff @(posedge clk_regs) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Combinational read ports, with optional same-cycle WB forwarding.
    always_comb begin
        rs_data_w = '0;
        rs_busy_w = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            a = bus.rs_addr[i*AW +: AW];
            if (a != '0) begin
                rs_data_w[i*XLEN +: XLEN] = regs[a];
                rs_busy_w[i]              = busy[a];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.rd == a)) begin
                rs_data_w[i*XLEN +: XLEN] = bus.din;
                if (!(bus.iss_valid && (bus.iss_rd == a))) begin
                    rs_busy_w[i] = 1'b0;
                end
            end
`endif
        end
    end

    assign bus.rs_data  = rs_data_w;
    assign bus.rs_busy  = rs_busy_w;
    assign bus.busy_cnt = busy_cnt;
    assign bus.any_busy = (busy_cnt != '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb with a queue-based scoreboard.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = $clog2(NREG);

    typedef struct {
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic [AW:0]         cnt;
        logic                any;
    } exp_t;

    typedef struct {
        logic            rst;
        logic [AW-1:0]   a [NRD];
        logic            iss;
        logic [AW-1:0]   iss_rd;
        logic            wrt;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] din;
        logic            flush;
    } stim_t;

    logic clk_regs = 1'b0;
    logic rst;
    always #5 clk_regs = ~clk_regs;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
        .clk_regs (clk_regs),
        .rst      (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    stim_t           cur;

    // Architectural effect of one clock edge with the currently applied inputs.
    task automatic model_edge();
        if (!cur.rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (cur.flush)
                    m_busy[r] = cur.iss && (cur.iss_rd == r);
                else if (cur.iss && cur.iss_rd == r)
                    m_busy[r] = 1;
                else if (cur.wrt && cur.rd == r)
                    m_busy[r] = 0;
            end
            if (cur.wrt && cur.rd != 0) m_regs[cur.rd] = cur.din;
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        int n = 0;
        e.data = '0;
        e.busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [XLEN-1:0] d;
            logic b;
            d = (cur.a[i] == 0) ? '0 : m_regs[cur.a[i]];
            b = (cur.a[i] == 0) ? 1'b0 : m_busy[cur.a[i]];
`ifdef REGFILE_BYPASS_EN
            if (cur.wrt && cur.rd != 0 && cur.rd == cur.a[i]) begin
                d = cur.din;
                if (!(cur.iss && cur.iss_rd == cur.a[i])) b = 1'b0;
            end
`endif
            e.data[i*XLEN +: XLEN] = d;
            e.busy[i] = b;
        end
        for (int r = 0; r < NREG; r++) n += m_busy[r];
        e.cnt = (AW+1)'(n);
        e.any = (n != 0);
        return e;
    endfunction

    task automatic drive();
        rst           = cur.rst;
        for (int i = 0; i < NRD; i++) bus.rs_addr[i*AW +: AW] = cur.a[i];
        bus.iss_valid = cur.iss;
        bus.iss_rd    = cur.iss_rd;
        bus.reg_wrt   = cur.wrt;
        bus.rd        = cur.rd;
        bus.din       = cur.din;
        bus.flush     = cur.flush;
    endtask

    // One cycle: account for the edge just taken, apply new inputs, queue expectation.
    task automatic step(input stim_t s);
        @(posedge clk_regs);
        #1;
        model_edge();
        cur = s;
        drive();
        exp_q.push_back(model_expect());
    endtask

    function automatic stim_t idle(input int a0, input int a1);
        stim_t s;
        s.rst = 1'b1;
        s.a[0] = AW'(a0);
        s.a[1] = AW'(a1);
        s.iss = 0; s.iss_rd = '0;
        s.wrt = 0; s.rd = '0; s.din = '0;
        s.flush = 0;
        return s;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: outputs are valid mid-cycle once an expectation is queued.
    always @(negedge clk_regs) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int i = 0; i < NRD; i++) begin
                check($sformatf("rs_data%0d", i), bus.rs_data[i*XLEN +: XLEN], e.data[i*XLEN +: XLEN]);
                check($sformatf("rs_busy%0d", i), XLEN'(bus.rs_busy[i]), XLEN'(e.busy[i]));
            end
            check("busy_cnt", XLEN'(bus.busy_cnt), XLEN'(e.cnt));
            check("any_busy", XLEN'(bus.any_busy), XLEN'(e.any));
        end
    end

    initial begin
        stim_t s;
        cur = idle(0, 0);
        cur.rst = 1'b0;
        drive();

        // reset held two cycles, then read {5,0}
        s = idle(5, 0); s.rst = 1'b0;
        step(s);
        step(s);
        step(idle(5, 0));

        // write/read, including writes to r0
        s = idle(0, 0); s.wrt = 1; s.rd = 7; s.din = 32'hDEADBEEF; step(s);
        step(idle(7, 0));
        s = idle(7, 0); s.wrt = 1; s.rd = 0; s.din = 32'h1234; step(s);
        step(idle(0, 7));

        // scoreboard set then clear by writeback
        s = idle(3, 0); s.iss = 1; s.iss_rd = 3; step(s);
        s = idle(3, 0); s.wrt = 1; s.rd = 3; s.din = 32'h55; step(s);
        step(idle(3, 0));

        // issue beats simultaneous writeback on a busy register
        s = idle(9, 0); s.iss = 1; s.iss_rd = 9; step(s);
        s = idle(9, 0); s.iss = 1; s.iss_rd = 9; s.wrt = 1; s.rd = 9; s.din = 32'h99; step(s);
        step(idle(9, 0));

        // flush keeps only the same-cycle issue
        s = idle(1, 2); s.iss = 1; s.iss_rd = 1; step(s);
        s = idle(1, 2); s.iss = 1; s.iss_rd = 2; step(s);
        s = idle(4, 6); s.iss = 1; s.iss_rd = 4; step(s);
        s = idle(4, 6); s.flush = 1; s.iss = 1; s.iss_rd = 6; step(s);
        step(idle(6, 4));

        // same-cycle write to a busy register while reading it
        s = idle(10, 0); s.iss = 1; s.iss_rd = 10; step(s);
        s = idle(10, 10); s.wrt = 1; s.rd = 10; s.din = 32'hA5A5A5A5; step(s);
        step(idle(10, 0));

        // randomized traffic, biased toward a few registers to provoke hazards
        for (int n = 0; n < 400; n++) begin
            s.rst   = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < NRD; i++)
                s.a[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            s.iss    = ($urandom_range(0, 2) == 0);
            s.iss_rd = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            s.wrt    = ($urandom_range(0, 2) == 0);
            s.rd     = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            s.din    = $urandom;
            s.flush  = ($urandom_range(0, 19) == 0);
            step(s);
        end
        step(idle(0, 0));

        begin
            int budget = 0;
            while (exp_q.size() > 0 && budget < 10) begin
                @(posedge clk_regs);
                budget++;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the CowCat32 pipeline, successor to the 2R1W file.
- Adds:
  - configurable data width, register count and read-port count
  - a per-register scoreboard (busy bits) set at issue and cleared at writeback, so ID can detect RAW hazards
  - a flush input
  - an optional write-to-read bypass
- Sits between ID (read and issue) and WB (write).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, ≥2.
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk_regs  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-low; sampled only on rising clk_regs.
- rs_addr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rs_data  out  NRD*XLEN  packed read data, combinational.
- rs_busy  out  NRD  busy bit of each read address (0 for addr 0).
- iss_valid  in  1  ID issues an instruction writing iss_rd.
- iss_rd  in  AW  destination register being issued.
- reg_wrt  in  1  WB write enable.
- rd  in  AW  WB destination.
- din  in  XLEN  WB data.
- flush  in  1  clear all busy bits (pipeline flush / branch redirect).
- busy_cnt  out  AW+1  number of registers currently busy.
- any_busy  out  1  busy_cnt != 0.

Behaviour:
- Storage: NREG x XLEN array plus NREG busy bits. Register 0 reads 0 and is never busy; writes and issues to 0 are ignored.
- Reset (rst==0 at rising edge):
  - all registers and busy bits clear to 0
  - busy_cnt=0, any_busy=0, all rs_data=0, all rs_busy=0
  - reset overrides issue, write and flush in the same cycle
  - reset mid-operation discards pending busy state
- Read: rs_data[i] = regs[rs_addr[i]] combinationally, zero-latency; 0 when rs_addr[i]==0.
- Write: at rising edge with reg_wrt=1 and rd!=0, regs[rd]<=din; visible on rs_data next cycle (without bypass).
- Scoreboard update per register r≠0, at the rising edge:
  - flush=1: busy[r] <= (iss_valid && iss_rd==r). An issue in the flush cycle is kept; it comes from the redirected stream.
  - else iss_valid && iss_rd==r: busy[r] <= 1. Issue wins over a simultaneous writeback to the same register; a new producer is in flight.
  - else reg_wrt && rd==r: busy[r] <= 0.
  - else hold.
- Writeback to a register not busy is legal: data is written, busy stays 0.
- busy_cnt: registered count, kept consistent with the busy bits each cycle (popcount of next-state busy vector, or incremental ±1). Never exceeds NREG-1.
- rs_busy[i] = busy[rs_addr[i]], combinational. With the bypass enabled it is forced to 0 when a same-cycle write to that address is active and no same-cycle issue targets it.
- No hold-style self-assignment in the clocked logic. Each register is written only under the conditions above.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rs_data[i] = din when reg_wrt && rd==rs_addr[i] && rd!=0, else the array value. WB data is visible to ID in the same cycle.
  - rs_busy[i] is masked as described in Behaviour.
- Undefined:
  - no bypass; same-cycle reads return the old value and the old busy bit.
  - the pipeline must forward externally or stall one extra cycle.

Test Plan:
- Reset then read: hold rst=0 for 2 cycles, release, read rs_addr={5,0} -> rs_data all 0, rs_busy=0, busy_cnt=0.
- Write/read: write din=0xDEADBEEF to rd=7, next cycle read rs_addr[0]=7 -> 0xDEADBEEF. Write 0x1234 to rd=0 -> reading 0 gives 0.
- Scoreboard: issue rd=3 -> next cycle rs_busy[0]=1 for addr 3, busy_cnt=1. Write rd=3 din=0x55 -> next cycle busy clear, busy_cnt=0, data 0x55.
- Simultaneous issue and write to rd=9 (previously busy) -> busy stays 1, data written, busy_cnt unchanged.
- Flush: issue rd=1,2,4 over three cycles (busy_cnt=3), then flush with iss_valid=1, iss_rd=6 -> next cycle only reg 6 busy, busy_cnt=1.
- Bypass (REGFILE_BYPASS_EN): busy reg 10, same cycle reg_wrt rd=10 din=0xA5A5A5A5 while reading addr 10 -> rs_data=0xA5A5A5A5, rs_busy=0. Without the macro -> old value and rs_busy=1.
